// File: rtl/aead_serial_loader_pkg.sv
// rtl/aead_serial_loader_pkg.sv - shared types and constants for the AEAD serial loader
package aead_serial_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_STREAM,
        ST_WAIT,
        ST_START,
        ST_DONE
    } state_e;

    // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam int SER_BUS_W = 5;
    localparam int RND_BUS_W = 3;
    localparam int NONCE_W   = 128;

    // Stream length: longest of the key, nonce, AD and PT fields
    function automatic int stream_len(input int k, input int l, input int y);
        int m;
        m = NONCE_W;
        if (k > m) m = k;
        if (l > m) m = l;
        if (y > m) m = y;
        return m;
    endfunction

endpackage

// File: rtl/aead_serial_loader_lfsr.sv
// rtl/aead_serial_loader_lfsr.sv - 16-bit Galois LFSR random-pad source
// Ports: clk, rst (async, active-high), en_i (advance one step), state_o (current state).
// A zero seed would lock the LFSR, so it is replaced by the default seed.
module ascon_lfsr16
    import aead_serial_loader_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/aead_serial_loader.sv
// rtl/aead_serial_loader.sv - loads one parallel job and streams it serially into the AEAD core
// Ports: clk, rst (async, active-high); load_validxSI/load_readyxSO job handshake with
// key/nonce/ad/pt parallel inputs; aead_rstxSO core reset pulse; 5-bit serial buses for
// key/nonce/AD/PT (data on bit 0); 3-bit random buses (data on bit 2); encryption start/ready
// handshake with the core; busyxSO and donexSO status.
module aead_serial_loader
    import aead_serial_loader_pkg::*;
#(
    parameter int          K         = 128,
    parameter int          L         = 32,
    parameter int          Y         = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_validxSI,
    output logic                  load_readyxSO,
    input  logic [K-1:0]          key_inxSI,
    input  logic [NONCE_W-1:0]    nonce_inxSI,
    input  logic [L-1:0]          ad_inxSI,
    input  logic [Y-1:0]          pt_inxSI,
    output logic                  aead_rstxSO,
    output logic [SER_BUS_W-1:0]  keyxSO,
    output logic [SER_BUS_W-1:0]  noncexSO,
    output logic [SER_BUS_W-1:0]  associated_dataxSO,
    output logic [SER_BUS_W-1:0]  plain_textxSO,
    output logic [RND_BUS_W-1:0]  r_128xSO,
    output logic [RND_BUS_W-1:0]  r_ptxSO,
    output logic                  encryption_startxSO,
    input  logic                  encryption_readyxSI,
    output logic                  busyxSO,
    output logic                  donexSO
);

    localparam int N     = stream_len(K, L, Y);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [K-1:0]       key_sh_q;
    logic [NONCE_W-1:0] nonce_sh_q;
    logic [L-1:0]       ad_sh_q;
    logic [Y-1:0]       pt_sh_q;

    logic key_bit_q, nonce_bit_q, ad_bit_q, pt_bit_q, r128_bit_q, rpt_bit_q;
    logic aead_rst_q, start_q, busy_q, done_q, ready_q;

    logic        lfsr_en;
    logic [15:0] lfsr_state;
    logic        lfsr_unused;

    // The registered bus bits for stream cycle n are loaded on the edge that enters it,
    // so the LFSR steps on that same edge: once leaving RST and once per non-final STREAM cycle.
    assign lfsr_en = (state_q == ST_RST) || ((state_q == ST_STREAM) && (cnt_q != CNT_LAST));

    ascon_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (lfsr_en),
        .state_o (lfsr_state)
    );

    assign lfsr_unused = ^lfsr_state[15:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_sh_q    <= '0;
            nonce_sh_q  <= '0;
            ad_sh_q     <= '0;
            pt_sh_q     <= '0;
            key_bit_q   <= 1'b0;
            nonce_bit_q <= 1'b0;
            ad_bit_q    <= 1'b0;
            pt_bit_q    <= 1'b0;
            r128_bit_q  <= 1'b0;
            rpt_bit_q   <= 1'b0;
            aead_rst_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_validxSI) begin
                        key_sh_q   <= key_inxSI;
                        nonce_sh_q <= nonce_inxSI;
                        ad_sh_q    <= ad_inxSI;
                        pt_sh_q    <= pt_inxSI;
                        aead_rst_q <= 1'b1;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= ST_RST;
                    end
                end
                ST_RST, ST_STREAM: begin
                    if ((state_q == ST_STREAM) && (cnt_q == CNT_LAST)) begin
                        key_bit_q   <= 1'b0;
                        nonce_bit_q <= 1'b0;
                        ad_bit_q    <= 1'b0;
                        pt_bit_q    <= 1'b0;
                        r128_bit_q  <= 1'b0;
                        rpt_bit_q   <= 1'b0;
                        state_q     <= ST_WAIT;
                    end else begin
                        // Zero-fill makes shorter fields emit 0 once their bits run out
                        key_bit_q   <= key_sh_q[K-1];
                        nonce_bit_q <= nonce_sh_q[NONCE_W-1];
                        ad_bit_q    <= ad_sh_q[L-1];
                        pt_bit_q    <= pt_sh_q[Y-1];
                        r128_bit_q  <= lfsr_state[0];
                        rpt_bit_q   <= lfsr_state[1];
                        key_sh_q    <= {key_sh_q[K-2:0], 1'b0};
                        nonce_sh_q  <= {nonce_sh_q[NONCE_W-2:0], 1'b0};
                        ad_sh_q     <= {ad_sh_q[L-2:0], 1'b0};
                        pt_sh_q     <= {pt_sh_q[Y-2:0], 1'b0};
                        if (state_q == ST_RST) begin
                            aead_rst_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= ST_STREAM;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    start_q <= 1'b1;
                    state_q <= ST_START;
                end
                ST_START: begin
                    if (encryption_readyxSI) begin
                        start_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_readyxSO       = ready_q;
    assign aead_rstxSO         = aead_rst_q;
    assign keyxSO              = {{(SER_BUS_W-1){1'b0}}, key_bit_q};
    assign noncexSO            = {{(SER_BUS_W-1){1'b0}}, nonce_bit_q};
    assign associated_dataxSO  = {{(SER_BUS_W-1){1'b0}}, ad_bit_q};
    assign plain_textxSO       = {{(SER_BUS_W-1){1'b0}}, pt_bit_q};
    assign r_128xSO            = {r128_bit_q, {(RND_BUS_W-1){1'b0}}};
    assign r_ptxSO             = {rpt_bit_q, {(RND_BUS_W-1){1'b0}}};
    assign encryption_startxSO = start_q;
    assign busyxSO             = busy_q;
    assign donexSO             = done_q;

endmodule

// File: tb/tb_aead_serial_loader.sv
// tb/tb_aead_serial_loader.sv - directed self-checking bench for aead_serial_loader
module tb_aead_serial_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_validxSI;
    logic         load_readyxSO;
    logic [127:0] key_inxSI;
    logic [127:0] nonce_inxSI;
    logic [31:0]  ad_inxSI;
    logic [31:0]  pt_inxSI;
    logic         aead_rstxSO;
    logic [4:0]   keyxSO, noncexSO, associated_dataxSO, plain_textxSO;
    logic [2:0]   r_128xSO, r_ptxSO;
    logic         encryption_startxSO;
    logic         encryption_readyxSI;
    logic         busyxSO;
    logic         donexSO;

    int checks = 0;
    int errors = 0;

    aead_serial_loader #(
        .K(128), .L(32), .Y(32), .LFSR_SEED(16'h0000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_validxSI       (load_validxSI),
        .load_readyxSO       (load_readyxSO),
        .key_inxSI           (key_inxSI),
        .nonce_inxSI         (nonce_inxSI),
        .ad_inxSI            (ad_inxSI),
        .pt_inxSI            (pt_inxSI),
        .aead_rstxSO         (aead_rstxSO),
        .keyxSO              (keyxSO),
        .noncexSO            (noncexSO),
        .associated_dataxSO  (associated_dataxSO),
        .plain_textxSO       (plain_textxSO),
        .r_128xSO            (r_128xSO),
        .r_ptxSO             (r_ptxSO),
        .encryption_startxSO (encryption_startxSO),
        .encryption_readyxSI (encryption_readyxSI),
        .busyxSO             (busyxSO),
        .donexSO             (donexSO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 128'(load_readyxSO), 128'd1);
        chk({tag, "_buses"}, 128'({keyxSO, noncexSO, associated_dataxSO, plain_textxSO, r_128xSO, r_ptxSO}), 128'd0);
        chk({tag, "_ctl"}, 128'({aead_rstxSO, encryption_startxSO, busyxSO, donexSO}), 128'd0);
    endtask

    // Golden Galois sequence from seed 0xACE1: ACE1 E270 7138 389C 1C4E 0E27 B313 ED89 C2C4
    task automatic run_stream(input logic [127:0] kv, input logic [31:0] av,
                              input logic [31:0] pv, input int ncyc, input bit chk_rnd);
        logic [8:0] r128_gold;
        logic [8:0] rpt_gold;
        r128_gold = 9'b011100001;
        rpt_gold  = 9'b001110000;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            chk($sformatf("key_n%0d", n), 128'(keyxSO), 128'(kv[127-n]));
            chk($sformatf("nonce_n%0d", n), 128'(noncexSO), 128'd1);
            chk($sformatf("ad_n%0d", n), 128'(associated_dataxSO), (n < 32) ? 128'(av[31-n]) : 128'd0);
            chk($sformatf("pt_n%0d", n), 128'(plain_textxSO), (n < 32) ? 128'(pv[31-n]) : 128'd0);
            chk($sformatf("ctl_n%0d", n), 128'({load_readyxSO, busyxSO, aead_rstxSO, encryption_startxSO}), 128'b0100);
            if (chk_rnd && n < 9) begin
                chk($sformatf("r128_n%0d", n), 128'(r_128xSO), 128'({r128_gold[n], 2'b00}));
                chk($sformatf("rpt_n%0d", n), 128'(r_ptxSO), 128'({rpt_gold[n], 2'b00}));
            end
        end
    endtask

    localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEY3 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] KEY4 = 128'h5555AAAA0000FFFF123456789ABCDEF0;

    initial begin
        rst = 1'b1;
        load_validxSI = 1'b0;
        key_inxSI = '0;
        nonce_inxSI = '0;
        ad_inxSI = '0;
        pt_inxSI = '0;
        encryption_readyxSI = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("idle");

        // Job 1: full run, accept at the next edge (edge 0)
        key_inxSI = KEY1;
        nonce_inxSI = '1;
        ad_inxSI = 32'hDEADBEEF;
        pt_inxSI = 32'h12345678;
        load_validxSI = 1'b1;
        @(negedge clk);
        load_validxSI = 1'b0;
        key_inxSI = '0;
        ad_inxSI = '0;
        pt_inxSI = '0;
        chk("c1_rst", 128'({aead_rstxSO, busyxSO, load_readyxSO}), 128'b110);
        chk("c1_buses", 128'({keyxSO, associated_dataxSO, r_128xSO}), 128'd0);
        run_stream(KEY1, 32'hDEADBEEF, 32'h12345678, 128, 1'b1);
        @(negedge clk);
        chk("c130_wait", 128'({encryption_startxSO, aead_rstxSO, keyxSO, noncexSO, r_128xSO, r_ptxSO}), 128'd0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk($sformatf("start_hold%0d", c), 128'({encryption_startxSO, donexSO, busyxSO, load_readyxSO}), 128'b1010);
        end
        encryption_readyxSI = 1'b1;
        @(negedge clk);
        encryption_readyxSI = 1'b0;
        chk("done_pulse", 128'({encryption_startxSO, donexSO, busyxSO, load_readyxSO}), 128'b0110);
        @(negedge clk);
        chk("after_done", 128'({encryption_startxSO, donexSO, busyxSO, load_readyxSO}), 128'b0001);

        // Job 2: asynchronous reset at stream cycle 40
        key_inxSI = KEY4;
        ad_inxSI = 32'h0F0F0F0F;
        pt_inxSI = 32'hA5A5A5A5;
        load_validxSI = 1'b1;
        @(negedge clk);
        load_validxSI = 1'b0;
        chk("j2_rst", 128'(aead_rstxSO), 128'd1);
        run_stream(KEY4, 32'h0F0F0F0F, 32'hA5A5A5A5, 41, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("postrst");

        // Job 3 accepted; job 4 held on the inputs with valid high throughout
        key_inxSI = KEY3;
        ad_inxSI = 32'hCAFEF00D;
        pt_inxSI = 32'h87654321;
        load_validxSI = 1'b1;
        @(negedge clk);
        chk("j3_rst", 128'({aead_rstxSO, load_readyxSO}), 128'b10);
        key_inxSI = KEY4;
        ad_inxSI = 32'h0F0F0F0F;
        pt_inxSI = 32'hA5A5A5A5;
        run_stream(KEY3, 32'hCAFEF00D, 32'h87654321, 128, 1'b1);
        @(negedge clk);
        chk("j3_wait", 128'(encryption_startxSO), 128'd0);
        encryption_readyxSI = 1'b1;
        @(negedge clk);
        chk("j3_start_one", 128'({encryption_startxSO, donexSO}), 128'b10);
        @(negedge clk);
        chk("j3_done", 128'({encryption_startxSO, donexSO, load_readyxSO}), 128'b010);
        @(negedge clk);
        chk("j3_idle", 128'({donexSO, busyxSO, load_readyxSO}), 128'b001);
        @(negedge clk);
        load_validxSI = 1'b0;
        chk("j4_rst", 128'({aead_rstxSO, busyxSO, load_readyxSO, encryption_startxSO}), 128'b1100);
        run_stream(KEY4, 32'h0F0F0F0F, 32'hA5A5A5A5, 32, 1'b0);
        chk("j4_no_start", 128'(encryption_startxSO), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
